// File: rtl/mc_chroma_ref_buf_pkg.sv
// Shared constants and write-page FSM encoding for the chroma MC reference buffer.
package mc_chroma_ref_buf_pkg;

    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_WIN_W       = 96;
    localparam int DEF_WIN_H       = 96;
    localparam int DEF_IDX_WIDTH   = 8;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_LOAD  = 2'd1,
        WR_READY = 2'd2
    } wr_state_t;

endpackage

// File: rtl/mc_chroma_ref_bank.sv
// Simple dual-port RAM wrapper: one write port, one registered read port.
module mc_chroma_ref_bank #(
    parameter int DW    = 64,
    parameter int DEPTH = 576,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_reg [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mc_chroma_ref_buf.sv
// Ping-pong U/V search-window buffer answering 8-pixel chroma reference fetches
// with one-cycle latency, including right/bottom edge padding.
module mc_chroma_ref_buf
    import mc_chroma_ref_buf_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int WIN_H       = DEF_WIN_H,
    parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_en_i,
    input  logic [IDX_WIDTH-1:0]         rd_idx_x_i,
    input  logic [IDX_WIDTH-1:0]         rd_idx_y_i,
    input  logic                         rd_sel_i,
    output logic [8*PIXEL_WIDTH-1:0]     rd_pel_o,
    input  logic                         ld_start_i,
    input  logic                         ld_wen_i,
    input  logic                         ld_sel_i,
    input  logic [$clog2(WIN_W/8)-1:0]   ld_wx_i,
    input  logic [$clog2(WIN_H)-1:0]     ld_wy_i,
    input  logic [8*PIXEL_WIDTH-1:0]     ld_dat_i,
    input  logic                         ld_done_i,
    output logic                         ld_ready_o,
    input  logic                         swap_i,
    output logic                         act_valid_o,
    output logic                         swap_err_o
);

    localparam int WORD_W = 8 * PIXEL_WIDTH;
    localparam int NW     = WIN_W / 8;
    localparam int HW     = WIN_W / 16;
    localparam int DEPTH  = WIN_H * HW;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = IDX_WIDTH + 1;

    wr_state_t state_reg;
    logic      page_reg;
    logic      act_valid_reg;
    logic      ld_ready_reg;
    logic      swap_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WR_IDLE;
            page_reg      <= 1'b0;
            act_valid_reg <= 1'b0;
            ld_ready_reg  <= 1'b1;
            swap_err_reg  <= 1'b0;
        end else begin
            swap_err_reg <= swap_i && (state_reg != WR_READY);
            case (state_reg)
                WR_IDLE: begin
                    if (ld_start_i) begin
                        state_reg    <= WR_LOAD;
                        ld_ready_reg <= 1'b0;
                    end
                end
                WR_LOAD: begin
                    if (ld_done_i) begin
                        state_reg <= WR_READY;
                    end
                end
                WR_READY: begin
                    if (swap_i) begin
                        state_reg     <= WR_IDLE;
                        ld_ready_reg  <= 1'b1;
                        page_reg      <= ~page_reg;
                        act_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= WR_IDLE;
                    ld_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Load side always targets the inactive page; out-of-window words are dropped.
    logic          wr_ok;
    logic [AW-1:0] wr_addr;

    assign wr_ok   = !rst && (state_reg == WR_LOAD) && ld_wen_i &&
                     (int'(ld_wx_i) < NW) && (int'(ld_wy_i) < WIN_H);
    assign wr_addr = AW'(int'(ld_wy_i) * HW + int'(ld_wx_i >> 1));

    // Clamp to the last word column / row, then fetch word w from one bank and w+1 from the other.
    logic [IDX_WIDTH-1:0] rd_word;
    logic [IDX_WIDTH-1:0] rd_wc;
    logic [IDX_WIDTH-1:0] rd_row;
    logic [IDX_WIDTH-1:0] w_even;
    logic [IDX_WIDTH-1:0] w_odd;
    logic [AW-1:0]        rd_addr_even;
    logic [AW-1:0]        rd_addr_odd;

    always_comb begin
        rd_word = rd_idx_x_i >> 3;
        rd_wc   = (int'(rd_word) > NW - 1) ? IDX_WIDTH'(NW - 1) : rd_word;
        rd_row  = (int'(rd_idx_y_i) > WIN_H - 1) ? IDX_WIDTH'(WIN_H - 1) : rd_idx_y_i;
        w_even  = rd_wc[0] ? rd_wc + IDX_WIDTH'(1) : rd_wc;
        w_odd   = rd_wc[0] ? rd_wc : rd_wc + IDX_WIDTH'(1);
        if (int'(w_even) > NW - 1) begin
            w_even = IDX_WIDTH'(NW - 2);
        end
        rd_addr_even = AW'(int'(rd_row) * HW + int'(w_even >> 1));
        rd_addr_odd  = AW'(int'(rd_row) * HW + int'(w_odd >> 1));
    end

    logic           zero_reg;
    logic [IDX_WIDTH-1:0] rd_x_reg;
    logic [PW-1:0]  rd_base_reg;
    logic [1:0]     rd_src_reg;
    logic           rd_odd_first_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_reg         <= 1'b1;
            rd_x_reg         <= '0;
            rd_base_reg      <= '0;
            rd_src_reg       <= '0;
            rd_odd_first_reg <= 1'b0;
        end else if (rd_en_i) begin
            zero_reg         <= !act_valid_reg;
            rd_x_reg         <= rd_idx_x_i;
            rd_base_reg      <= PW'({rd_wc, 3'b000});
            rd_src_reg       <= {page_reg, rd_sel_i};
            rd_odd_first_reg <= rd_wc[0];
        end
    end

    logic [WORD_W-1:0] bank_dout [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_bank
        localparam logic PG = 1'((gi >> 2) & 1);
        localparam logic PL = 1'((gi >> 1) & 1);
        localparam logic BK = 1'(gi & 1);

        logic          bank_we;
        logic          bank_re;
        logic [AW-1:0] bank_raddr;

        assign bank_we    = wr_ok && (page_reg != PG) && (ld_sel_i == PL) && (ld_wx_i[0] == BK);
        assign bank_re    = rd_en_i && (page_reg == PG) && (rd_sel_i == PL);
        assign bank_raddr = BK ? rd_addr_odd : rd_addr_even;

        mc_chroma_ref_bank #(
            .DW    (WORD_W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (wr_addr),
            .wdata (ld_dat_i),
            .re    (bank_re),
            .raddr (bank_raddr),
            .rdata (bank_dout[gi])
        );
    end

    // pair holds 16 consecutive pixels starting at the first fetched word, leftmost in the MSBs.
    logic [WORD_W-1:0]   even_q;
    logic [WORD_W-1:0]   odd_q;
    logic [2*WORD_W-1:0] pair;
    logic [WORD_W-1:0]   rot;

    assign even_q = bank_dout[{rd_src_reg, 1'b0}];
    assign odd_q  = bank_dout[{rd_src_reg, 1'b1}];
    assign pair   = rd_odd_first_reg ? {odd_q, even_q} : {even_q, odd_q};

    for (genvar gi = 0; gi < 8; gi++) begin : g_pix
        logic [PW-1:0]       pos;
        logic [PW-1:0]       pos_c;
        logic [3:0]          k;
        logic [2*WORD_W-1:0] sh;

        assign pos   = {1'b0, rd_x_reg} + PW'(gi);
        assign pos_c = (pos > PW'(WIN_W - 1)) ? PW'(WIN_W - 1) : pos;
        assign k     = 4'(pos_c - rd_base_reg);
        assign sh    = pair << (k * PIXEL_WIDTH);
        assign rot[WORD_W-1-gi*PIXEL_WIDTH -: PIXEL_WIDTH] = sh[2*WORD_W-1 -: PIXEL_WIDTH];
    end

    assign rd_pel_o    = zero_reg ? '0 : rot;
    assign ld_ready_o  = ld_ready_reg;
    assign act_valid_o = act_valid_reg;
    assign swap_err_o  = swap_err_reg;

endmodule

// File: tb/tb_mc_chroma_ref_buf.sv
// Randomized bench for mc_chroma_ref_buf against a pixel-array reference model.
module tb_mc_chroma_ref_buf;

    localparam int WW   = 96;
    localparam int WH   = 96;
    localparam int NWD  = WW / 8;
    localparam int FULL = 2 * WH * NWD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [7:0]  rd_y = '0;
    logic        rd_sel = 1'b0;
    logic [63:0] rd_pel;
    logic        ld_start = 1'b0;
    logic        ld_wen = 1'b0;
    logic        ld_sel = 1'b0;
    logic [3:0]  ld_wx = '0;
    logic [6:0]  ld_wy = '0;
    logic [63:0] ld_dat = '0;
    logic        ld_done = 1'b0;
    logic        ld_ready;
    logic        swap = 1'b0;
    logic        act_valid;
    logic        swap_err;

    always #5 clk = ~clk;

    mc_chroma_ref_buf dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rd_en),
        .rd_idx_x_i (rd_x),
        .rd_idx_y_i (rd_y),
        .rd_sel_i   (rd_sel),
        .rd_pel_o   (rd_pel),
        .ld_start_i (ld_start),
        .ld_wen_i   (ld_wen),
        .ld_sel_i   (ld_sel),
        .ld_wx_i    (ld_wx),
        .ld_wy_i    (ld_wy),
        .ld_dat_i   (ld_dat),
        .ld_done_i  (ld_done),
        .ld_ready_o (ld_ready),
        .swap_i     (swap),
        .act_valid_o(act_valid),
        .swap_err_o (swap_err)
    );

    // Reference model: pixel arrays per page/plane plus page pointer and load state.
    logic [7:0]  mem [2][2][WH][WW];
    int          m_page = 0;
    int          m_state = 0;
    bit          m_valid = 1'b0;
    logic [63:0] exp_pel = '0;
    bit          exp_ready = 1'b1;
    bit          exp_err = 1'b0;
    bit          chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input int pg, input int pl, input int x, input int y);
        logic [63:0] r;
        int row;
        int p;
        row = (y >= WH) ? WH - 1 : y;
        for (int i = 0; i < 8; i++) begin
            p = x + i;
            if (p >= WW) p = WW - 1;
            r[63-8*i -: 8] = mem[pg][pl][row][p];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        int old_st;
        if (rst) begin
            m_page    = 0;
            m_state   = 0;
            m_valid   = 1'b0;
            exp_pel   = '0;
            exp_ready = 1'b1;
            exp_err   = 1'b0;
        end else begin
            if (rd_en) exp_pel = m_valid ? model_read(m_page, int'(rd_sel), int'(rd_x), int'(rd_y)) : '0;
            old_st = m_state;
            if (old_st == 1 && ld_wen && int'(ld_wx) < NWD && int'(ld_wy) < WH) begin
                for (int i = 0; i < 8; i++)
                    mem[1-m_page][ld_sel][ld_wy][int'(ld_wx)*8+i] = ld_dat[63-8*i -: 8];
            end
            exp_err = 1'b0;
            if (old_st == 0 && ld_start) m_state = 1;
            if (old_st == 1 && ld_done) m_state = 2;
            if (swap) begin
                if (old_st == 2) begin
                    m_page  = 1 - m_page;
                    m_valid = 1'b1;
                    m_state = 0;
                end else begin
                    exp_err = 1'b1;
                end
            end
            exp_ready = (m_state == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check64("rd_pel", rd_pel, exp_pel);
            check1("ld_ready", ld_ready, exp_ready);
            check1("act_valid", act_valid, m_valid);
            check1("swap_err", swap_err, exp_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] gen_word(input int kind, input int wx, input int wy);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            case (kind)
                0:       w[63-8*i -: 8] = {4'(wy), 4'(wx)};
                1:       w[63-8*i -: 8] = 8'(wx * 8 + i);
                2:       w[63-8*i -: 8] = 8'hAA;
                default: w[63-8*i -: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    task automatic rand_read();
        rd_en  = 1'($urandom_range(0, 1));
        rd_x   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(96, 255)) : 8'($urandom_range(0, 95));
        rd_y   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(96, 255)) : 8'($urandom_range(0, 95));
        rd_sel = 1'($urandom_range(0, 1));
    endtask

    // Streams nwords words (U plane first); ld_done coincides with the final word of a full page.
    task automatic load_page(input int ku, input int kv, input bit rreads, input int nwords);
        int n = 0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int pl = 0; pl < 2 && n < nwords; pl++)
            for (int wy = 0; wy < WH && n < nwords; wy++)
                for (int wx = 0; wx < NWD && n < nwords; wx++) begin
                    ld_wen  = 1'b1;
                    ld_sel  = 1'(pl);
                    ld_wx   = 4'(wx);
                    ld_wy   = 7'(wy);
                    ld_dat  = gen_word(pl != 0 ? kv : ku, wx, wy);
                    n++;
                    ld_done = (n == FULL);
                    if (rreads) rand_read();
                    tick();
                end
        ld_wen  = 1'b0;
        ld_done = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic read_lit(input string name, input int x, input int y, input bit sel,
                            input logic [63:0] exp);
        rd_en  = 1'b1;
        rd_x   = 8'(x);
        rd_y   = 8'(y);
        rd_sel = sel;
        tick();
        rd_en = 1'b0;
        check64(name, rd_pel, exp);
    endtask

    initial begin
        repeat (2) tick();
        chk_en = 1'b1;
        tick();
        check1("reset_ld_ready", ld_ready, 1'b1);
        check64("reset_rd_pel", rd_pel, 64'h0);
        rst = 1'b0;

        // Page A: U = {wy,wx} nibbles, V = pixel x.
        load_page(0, 1, 1'b0, FULL);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check1("t1_act_valid", act_valid, 1'b1);
        read_lit("t1_u_row5", 0, 5, 1'b0, 64'h5050505050505050);
        tick();
        check64("t1_hold", rd_pel, 64'h5050505050505050);

        read_lit("t2_unaligned", 13, 2, 1'b1, 64'h0D0E0F1011121314);
        for (int i = 0; i < 16; i++) begin
            rd_en  = 1'b1;
            rd_x   = 8'(i * 5 + 1);
            rd_y   = 8'(i);
            rd_sel = 1'b1;
            tick();
        end
        rd_en = 1'b0;

        read_lit("t3_right_edge", 92, 0, 1'b1, 64'h5C5D5E5F5F5F5F5F);
        read_lit("t3_far_right", 200, 7, 1'b1, 64'h5F5F5F5F5F5F5F5F);
        read_lit("t3_bottom_pad", 0, 100, 1'b0, 64'hF0F0F0F0F0F0F0F0);

        // Page B loads while A is read; a read coinciding with swap still sees A.
        load_page(3, 2, 1'b1, FULL);
        rd_en  = 1'b1;
        rd_x   = 8'd0;
        rd_y   = 8'd0;
        rd_sel = 1'b1;
        swap   = 1'b1;
        tick();
        swap = 1'b0;
        check64("t4_read_at_swap", rd_pel, 64'h0001020304050607);
        tick();
        rd_en = 1'b0;
        check64("t4_read_after_swap", rd_pel, 64'hAAAAAAAAAAAAAAAA);

        // Premature swap during LOAD is rejected, then the load completes normally.
        load_page(3, 1, 1'b1, 50);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check1("t5_swap_err", swap_err, 1'b1);
        check1("t5_still_valid", act_valid, 1'b1);
        tick();
        check1("t5_err_pulse_end", swap_err, 1'b0);
        load_page(3, 1, 1'b1, FULL);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        read_lit("t5_after_good_swap", 13, 2, 1'b1, 64'h0D0E0F1011121314);

        // Reset in the middle of a load.
        load_page(0, 0, 1'b1, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("t6_ld_ready", ld_ready, 1'b1);
        check1("t6_act_valid", act_valid, 1'b0);
        check64("t6_rd_pel", rd_pel, 64'h0);
        read_lit("t6_read_invalid", 5, 5, 1'b0, 64'h0);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check1("t6_swap_idle_err", swap_err, 1'b1);
        load_page(0, 1, 1'b1, FULL);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_read();
            tick();
        end
        read_lit("t6_final_row5", 0, 5, 1'b0, 64'h5050505050505050);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
